// File: rtl/stable_word_capture_pkg.sv
// Shared defaults and width helpers for the stable word capture stage.
package stable_word_capture_pkg;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_STABLE_CYCLES = 2;
    localparam int DEF_FIFO_DEPTH    = 4;

    // Counter must hold 0..stable inclusive.
    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction
endpackage

// File: rtl/stable_word_capture_if.sv
// Bus between the crossed-data producer/consumer and the capture stage.
interface stable_word_capture_if
    import stable_word_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [AW:0]           fill_level;
    logic                  overflow;

    modport master (output data_in, output out_ready,
                    input out_data, input out_valid, input fill_level, input overflow);
    modport slave  (input data_in, input out_ready,
                    output out_data, output out_valid, output fill_level, output overflow);
endinterface

// File: rtl/stable_word_capture_fifo.sv
// Show-ahead single-clock FIFO: head word is presented combinationally.
// Writes when full are ignored unless a read frees a slot in the same cycle.
module sync_fifo_sa #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic                  w_wr;
    logic                  w_rd;

    assign empty   = (r_level == '0);
    assign full    = (r_level == (AW+1)'(FIFO_DEPTH));
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_rd    = rd_en && !empty;
    assign w_wr    = wr_en && (!full || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/stable_word_capture.sv
// Turns a free-running crossed bus into one transaction per stable change,
// buffered in a show-ahead FIFO with a sticky overflow flag.
module stable_word_capture
    import stable_word_capture_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    stable_word_capture_if.slave bus
);
    localparam int CW = cnt_width(STABLE_CYCLES);

    logic [DATA_WIDTH-1:0] r_cand;
    logic [DATA_WIDTH-1:0] r_last;
    logic [CW-1:0]         r_cnt;
    logic                  r_have_last;
    logic                  r_overflow;
    logic                  w_same;
    logic                  w_accept;
    logic                  w_repeat;
    logic                  w_new;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;

    assign w_same   = (bus.data_in == r_cand);
    assign w_accept = w_same && (r_cnt == CW'(STABLE_CYCLES - 1));
    assign w_repeat = r_have_last && (r_cand == r_last);
    assign w_new    = w_accept && !w_repeat;
    assign w_pop    = bus.out_valid && bus.out_ready;
    assign w_push   = w_new && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand      <= '0;
            r_cnt       <= '0;
            r_last      <= '0;
            r_have_last <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (!w_same) begin
                r_cand <= bus.data_in;
                r_cnt  <= '0;
            end else if (r_cnt < CW'(STABLE_CYCLES)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // A dropped word still becomes "last" so it is not re-offered later.
            if (w_new) begin
                r_last      <= r_cand;
                r_have_last <= 1'b1;
            end
            if (w_new && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    sync_fifo_sa #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (r_cand),
        .rd_en   (w_pop),
        .rd_data (bus.out_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (bus.fill_level)
    );

    assign bus.out_valid = !w_empty;
    assign bus.overflow  = r_overflow;
endmodule
